// File: rtl/dly_tap_ctrl.sv
// Tap-control sequencer for the input-delay primitive: optional DLY_LOAD, then
// single-tap DLY_ADJ steps toward the requested tap, verifying each step by read-back.
module dly_tap_ctrl #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       START,
  input  logic       LOAD_FIRST,
  input  logic [5:0] TARGET_TAP,
  input  logic [5:0] DLY_TAP_VALUE,
  output logic       DLY_LOAD,
  output logic       DLY_ADJ,
  output logic       DLY_INCDEC,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [5:0] STEP_COUNT
);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 4) begin : g_bad_pulse
    $fatal(1, "%m: PULSE_CYCLES=%0d outside legal range 1..4", PULSE_CYCLES);
  end
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $fatal(1, "%m: SETTLE_CYCLES=%0d outside legal range 2..15", SETTLE_CYCLES);
  end

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, CMP, ADJ_HI, ADJ_LO, CHECK
  } state_t;

  state_t     state;
  logic [5:0] target;
  logic [5:0] prev_tap;
  logic [3:0] cnt;
  logic       rdy;
  logic       step_ok;

  assign step_ok = DLY_INCDEC ? (DLY_TAP_VALUE == prev_tap + 6'd1)
                              : (DLY_TAP_VALUE == prev_tap - 6'd1);

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      target     <= '0;
      prev_tap   <= '0;
      cnt        <= '0;
      rdy        <= 1'b0;
      DLY_LOAD   <= 1'b0;
      DLY_ADJ    <= 1'b0;
      DLY_INCDEC <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      STEP_COUNT <= '0;
    end else begin
      // rdy holds off acceptance for the first edge after reset release
      rdy   <= 1'b1;
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (START && rdy) begin
            target     <= TARGET_TAP;
            STEP_COUNT <= '0;
            BUSY       <= 1'b1;
            if (LOAD_FIRST) begin
              DLY_LOAD <= 1'b1;
              cnt      <= PULSE_LAST;
              state    <= LOAD_HI;
            end else begin
              state <= CMP;
            end
          end
        end
        LOAD_HI: begin
          if (cnt == '0) begin
            DLY_LOAD <= 1'b0;
            cnt      <= SETTLE_LAST;
            state    <= LOAD_LO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        LOAD_LO: begin
          if (cnt == '0) state <= CMP;
          else           cnt   <= cnt - 4'd1;
        end
        CMP: begin
          if (DLY_TAP_VALUE == target) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            DLY_INCDEC <= (target > DLY_TAP_VALUE);
            prev_tap   <= DLY_TAP_VALUE;
            if (STEP_COUNT != 6'd63) STEP_COUNT <= STEP_COUNT + 6'd1;
            DLY_ADJ <= 1'b1;
            cnt     <= PULSE_LAST;
            state   <= ADJ_HI;
          end
        end
        ADJ_HI: begin
          if (cnt == '0) begin
            DLY_ADJ <= 1'b0;
            cnt     <= SETTLE_LAST;
            state   <= ADJ_LO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ADJ_LO: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 4'd1;
        end
        CHECK: begin
          if (step_ok) begin
            state <= CMP;
          end else begin
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Bench for dly_tap_ctrl: behavioural delay-primitive model plus per-scenario
// tasks checking pulse shapes, step counts, latencies and final tap positions.
module tb_dly_tap_ctrl;

  localparam int P    = 2;
  localparam int S    = 2;
  localparam int STEP = P + S + 2;

  logic       CLK_IN = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       LOAD_FIRST = 1'b0;
  logic [5:0] TARGET_TAP = '0;
  logic [5:0] DLY_TAP_VALUE;
  logic       DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR;
  logic [5:0] STEP_COUNT;

  int checks = 0;
  int errors = 0;

  dly_tap_ctrl #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .START(START), .LOAD_FIRST(LOAD_FIRST),
    .TARGET_TAP(TARGET_TAP), .DLY_TAP_VALUE(DLY_TAP_VALUE),
    .DLY_LOAD(DLY_LOAD), .DLY_ADJ(DLY_ADJ), .DLY_INCDEC(DLY_INCDEC),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .STEP_COUNT(STEP_COUNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Delay primitive: two-stage synchroniser + rising-edge detect on LOAD/ADJ.
  logic [5:0] prim_tap = '0;
  logic [5:0] prim_delay = 6'd10;
  logic       stuck_en = 1'b0;
  logic [5:0] stuck_val = '0;
  logic       l1 = 0, l2 = 0, l3 = 0, a1 = 0, a2 = 0, a3 = 0;

  assign DLY_TAP_VALUE = stuck_en ? stuck_val : prim_tap;

  always @(posedge CLK_IN) begin
    l1 <= DLY_LOAD; l2 <= l1; l3 <= l2;
    a1 <= DLY_ADJ;  a2 <= a1; a3 <= a2;
    if (l2 && !l3) prim_tap <= prim_delay;
    else if (a2 && !a3) begin
      if (DLY_INCDEC && prim_tap != 6'd63)      prim_tap <= prim_tap + 6'd1;
      else if (!DLY_INCDEC && prim_tap != 6'd0) prim_tap <= prim_tap - 6'd1;
    end
  end

  // Free-running event counters sampled mid-cycle; scenarios take deltas.
  int   cyc = 0, n_lrise = 0, n_lcyc = 0, n_arise = 0, n_acyc = 0;
  int   n_up = 0, n_dn = 0, n_done = 0, n_err = 0, n_viol = 0;
  int   last_rise = 0;
  logic pl = 0, pa = 0, rise_dir = 0, first_rise = 1;

  always @(negedge CLK_IN) begin
    cyc <= cyc + 1;
    if (DLY_LOAD) n_lcyc <= n_lcyc + 1;
    if (DLY_LOAD && !pl) n_lrise <= n_lrise + 1;
    if (DLY_ADJ) n_acyc <= n_acyc + 1;
    if (DLY_ADJ && !pa) begin
      n_arise <= n_arise + 1;
      if (DLY_INCDEC) n_up <= n_up + 1; else n_dn <= n_dn + 1;
      rise_dir   <= DLY_INCDEC;
      last_rise  <= cyc;
      first_rise <= 1'b0;
      if (!first_rise && (cyc - last_rise) != STEP) n_viol <= n_viol + 1;
    end else if (DLY_ADJ && DLY_INCDEC !== rise_dir) n_viol <= n_viol + 1;
    else if (!BUSY) first_rise <= 1'b1;
    if ((DLY_LOAD && DLY_ADJ) || (DONE && ERROR)) n_viol <= n_viol + 1;
    if (DONE)  n_done <= n_done + 1;
    if (ERROR) n_err  <= n_err + 1;
    pl <= DLY_LOAD;
    pa <= DLY_ADJ;
  end

  int b_lrise, b_lcyc, b_arise, b_acyc, b_up, b_dn, b_done, b_err, b_viol;
  int d_lrise, d_lcyc, d_arise, d_acyc, d_up, d_dn, d_done, d_err, d_viol;

  task automatic snap();
    b_lrise = n_lrise; b_lcyc = n_lcyc; b_arise = n_arise; b_acyc = n_acyc;
    b_up = n_up; b_dn = n_dn; b_done = n_done; b_err = n_err; b_viol = n_viol;
  endtask

  task automatic delta();
    d_lrise = n_lrise - b_lrise; d_lcyc = n_lcyc - b_lcyc;
    d_arise = n_arise - b_arise; d_acyc = n_acyc - b_acyc;
    d_up = n_up - b_up; d_dn = n_dn - b_dn;
    d_done = n_done - b_done; d_err = n_err - b_err; d_viol = n_viol - b_viol;
  endtask

  // Reference: the delay line moves one tap per step from its starting point
  // (or from the load value) straight to the target.
  function automatic void ref_op(input logic [5:0] t0, input bit lf, input logic [5:0] tgt,
                                 input logic [5:0] dly, output int n, output bit up, output int lat);
    int s;
    s   = lf ? int'(dly) : int'(t0);
    up  = int'(tgt) > s;
    n   = up ? int'(tgt) - s : s - int'(tgt);
    lat = (lf ? P + S : 0) + n * STEP + 1;
  endfunction

  task automatic run_op(input bit lf, input logic [5:0] tgt, output int lat, output bit to,
                        output bit busy0, output bit fin_busy, output logic [5:0] sc, output bit post);
    @(negedge CLK_IN); #1;
    START = 1'b1; LOAD_FIRST = lf; TARGET_TAP = tgt;
    snap();
    @(posedge CLK_IN); #1;
    START = 1'b0; LOAD_FIRST = 1'($urandom); TARGET_TAP = 6'($urandom);
    to = 1'b1; lat = 0; busy0 = 1'b0; fin_busy = 1'b1; sc = '0;
    for (int unsigned k = 0; k < 2000; k++) begin
      @(negedge CLK_IN);
      if (k == 0) busy0 = BUSY;
      if (DONE || ERROR) begin
        lat = int'(k); to = 1'b0; fin_busy = BUSY; sc = STEP_COUNT;
        break;
      end
    end
    @(negedge CLK_IN); #1;
    post = DONE | ERROR;
    delta();
  endtask

  task automatic test_reset();
    bit seen;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK_IN);
    checks++;
    if ({DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, STEP_COUNT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, STEP_COUNT});
    end
    #1; START = 1'b1; LOAD_FIRST = 1'b1; TARGET_TAP = 6'd10; prim_delay = 6'd10; RST = 1'b1;
    @(negedge CLK_IN);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL start_first_edge: BUSY=%b, expected 0", BUSY); end
    @(negedge CLK_IN);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL start_second_edge: BUSY=%b, expected 1", BUSY); end
    #1 START = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < 200; k++) begin
      @(negedge CLK_IN);
      if (DONE) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || prim_tap !== 6'd10) begin
      errors++; $display("FAIL reset_first_op: done=%b tap=%0d, expected done=1 tap=10", seen, prim_tap);
    end
  endtask

  task automatic test_load();
    int lat, n, elat; bit to, b0, fb, post, up; logic [5:0] sc;
    prim_delay = 6'd10;
    ref_op(prim_tap, 1'b1, 6'd10, prim_delay, n, up, elat);
    run_op(1'b1, 6'd10, lat, to, b0, fb, sc, post);
    checks++;
    if (to || lat != elat) begin errors++; $display("FAIL load_latency: got %0d (timeout=%b), expected %0d", lat, to, elat); end
    checks++;
    if (d_lrise != 1 || d_lcyc != P || d_arise != 0) begin
      errors++; $display("FAIL load_pulse: loads=%0d cycles=%0d adj=%0d, expected 1/%0d/0", d_lrise, d_lcyc, d_arise, P);
    end
    checks++;
    if (d_done != 1 || d_err != 0 || post || !b0 || fb || sc !== 6'd0 || prim_tap !== 6'd10) begin
      errors++;
      $display("FAIL load_result: done=%0d err=%0d post=%b busy=%b/%b step=%0d tap=%0d, expected 1 0 0 1/0 0 10",
               d_done, d_err, post, b0, fb, sc, prim_tap);
    end
  endtask

  task automatic test_step(input logic [5:0] tgt, input bit lf, input string name);
    int lat, n, elat; bit to, b0, fb, post, up; logic [5:0] sc;
    ref_op(prim_tap, lf, tgt, prim_delay, n, up, elat);
    run_op(lf, tgt, lat, to, b0, fb, sc, post);
    checks++;
    if (to || lat != elat) begin errors++; $display("FAIL %s_latency: got %0d (timeout=%b), expected %0d", name, lat, to, elat); end
    checks++;
    if (d_arise != n || d_acyc != n * P || d_up != (up ? n : 0) || d_dn != (up ? 0 : n)) begin
      errors++;
      $display("FAIL %s_adj: pulses=%0d cycles=%0d up=%0d dn=%0d, expected %0d pulses dir_up=%b", name, d_arise, d_acyc, d_up, d_dn, n, up);
    end
    checks++;
    if (int'(sc) != n || prim_tap !== tgt || d_done != 1 || d_err != 0 || post || d_viol != 0) begin
      errors++;
      $display("FAIL %s_result: step=%0d tap=%0d done=%0d err=%0d post=%b viol=%0d, expected step=%0d tap=%0d done=1",
               name, sc, prim_tap, d_done, d_err, post, d_viol, n, tgt);
    end
    checks++;
    if (d_lrise != int'(lf) || d_lcyc != int'(lf) * P) begin
      errors++; $display("FAIL %s_load: loads=%0d cycles=%0d, expected %0d", name, d_lrise, d_lcyc, int'(lf));
    end
  endtask

  task automatic test_stuck();
    int lat; bit to, b0, fb, post; logic [5:0] sc;
    stuck_val = 6'd20; stuck_en = 1'b1;
    run_op(1'b0, 6'd25, lat, to, b0, fb, sc, post);
    stuck_en = 1'b0;
    checks++;
    if (to || lat != STEP) begin errors++; $display("FAIL stuck_latency: got %0d (timeout=%b), expected %0d", lat, to, STEP); end
    checks++;
    if (d_arise != 1 || d_up != 1 || d_err != 1 || d_done != 0 || sc !== 6'd1 || fb || post) begin
      errors++;
      $display("FAIL stuck_error: adj=%0d up=%0d err=%0d done=%0d step=%0d busy=%b post=%b, expected 1 1 1 0 1 0 0",
               d_arise, d_up, d_err, d_done, sc, fb, post);
    end
  endtask

  task automatic test_abort();
    int cnt; logic prev; bit found;
    @(negedge CLK_IN); #1;
    START = 1'b1; LOAD_FIRST = 1'b0; TARGET_TAP = (prim_tap >= 6'd32) ? 6'd0 : 6'd63;
    snap();
    @(posedge CLK_IN); #1 START = 1'b0;
    cnt = 0; prev = 1'b0; found = 1'b0;
    for (int unsigned k = 0; k < 100; k++) begin
      @(negedge CLK_IN);
      if (DLY_ADJ && !prev) cnt++;
      prev = DLY_ADJ;
      if (cnt == 2) begin found = 1'b1; break; end
    end
    @(posedge CLK_IN); #2 RST = 1'b0;
    #1;
    checks++;
    if (!found || {DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, STEP_COUNT} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: reached=%b outputs=%b, expected reached=1 outputs all zero",
               found, {DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, STEP_COUNT});
    end
    repeat (3) @(negedge CLK_IN);
    #1 RST = 1'b1;
    repeat (6) @(negedge CLK_IN);
    #1 delta();
    checks++;
    if (d_done != 0 || d_err != 0) begin
      errors++; $display("FAIL abort_no_pulse: done=%0d err=%0d, expected 0 0", d_done, d_err);
    end
    test_step(6'd10, 1'b0, "abort_restart");
  endtask

  task automatic test_ignore_start();
    int n, elat; bit up, seen;
    ref_op(prim_tap, 1'b0, 6'd13, prim_delay, n, up, elat);
    @(negedge CLK_IN); #1;
    START = 1'b1; LOAD_FIRST = 1'b0; TARGET_TAP = 6'd13;
    snap();
    @(posedge CLK_IN); #1 START = 1'b0;
    repeat (2) @(negedge CLK_IN);
    #1 START = 1'b1; TARGET_TAP = 6'd40; LOAD_FIRST = 1'b1;
    repeat (5) @(negedge CLK_IN);
    #1 START = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < 500; k++) begin
      @(negedge CLK_IN);
      if (DONE) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || int'(STEP_COUNT) != n) begin
      errors++; $display("FAIL ignore_done: done=%b step=%0d, expected done=1 step=%0d", seen, STEP_COUNT, n);
    end
    repeat (4) @(negedge CLK_IN);
    #1 delta();
    checks++;
    if (d_done != 1 || d_lrise != 0 || prim_tap !== 6'd13 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: dones=%0d loads=%0d tap=%0d busy=%b, expected 1 0 13 0", d_done, d_lrise, prim_tap, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; logic [5:0] t2;
    @(negedge CLK_IN); #1;
    START = 1'b1; LOAD_FIRST = 1'b0; TARGET_TAP = prim_tap + 6'd2;
    t2 = prim_tap - 6'd1;
    @(posedge CLK_IN); #1 START = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < 200; k++) begin
      @(negedge CLK_IN);
      if (DONE) begin seen = 1'b1; break; end
    end
    #1 START = 1'b1; TARGET_TAP = t2;
    snap();
    @(posedge CLK_IN); #1 START = 1'b0;
    @(negedge CLK_IN);
    checks++;
    if (!seen || BUSY !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: first_done=%b busy=%b, expected 1 1", seen, BUSY);
    end
    seen = 1'b0;
    for (int unsigned k = 0; k < 200; k++) begin
      @(negedge CLK_IN);
      if (DONE) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || STEP_COUNT !== 6'd3 || prim_tap !== t2) begin
      errors++; $display("FAIL b2b_second: done=%b step=%0d tap=%0d, expected 1 3 %0d", seen, STEP_COUNT, prim_tap, t2);
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 15; i++) begin
      prim_delay = 6'($urandom);
      test_step(6'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step(6'd13, 1'b0, "step_up");
    test_step(6'd5, 1'b0, "step_down");
    prim_delay = 6'd0;
    test_step(6'd0, 1'b1, "load_zero");
    test_step(6'd63, 1'b0, "full_range");
    test_stuck();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
